// File: rtl/hls_bus_arbiter.sv
// hls_bus_arbiter: round-robin sharing of one HLS cmd/rsp bridge among N_REQ simple-bus masters
module hls_bus_arbiter #(
    parameter int N_REQ = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int PW = DATA_ADDR_WIDTH + DATA_WIDTH + 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      s_cmd_valid,
    output logic [N_REQ-1:0]      s_cmd_ready,
    input  logic [N_REQ*PW-1:0]   s_cmd_payload,
    output logic [N_REQ-1:0]      s_rsp_valid,
    output logic [DATA_WIDTH-1:0] s_rsp_data,
    output logic                  s_rsp_last,
    output logic                  m_cmd_valid,
    input  logic                  m_cmd_ready,
    output logic [PW-1:0]         m_cmd_payload,
    input  logic                  m_rsp_valid,
    input  logic [DATA_WIDTH-1:0] m_rsp_data,
    input  logic                  m_rsp_last,
    output logic [N_REQ-1:0]      grant,
    output logic                  rsp_orphan
);
    localparam int IW = $clog2(N_REQ);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_n;
    logic [IW-1:0] owner, owner_n, rr_ptr, rr_n, sel, cand, head;
    logic [IW-1:0] fifo [MAX_OUTSTANDING];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [PW-1:0] pay;
    logic found, full, empty, blk, acc, push, pop, is_wr, is_last;
    assign s_rsp_data = m_rsp_data;
    assign s_rsp_last = m_rsp_last;
    always_comb begin
        sel = owner;
        cand = owner;
        found = state == LOCKED;
        if (state == IDLE) begin
            // descending scan: the last hit is the nearest valid after rr_ptr
            for (int k = N_REQ; k >= 1; k--) begin
                cand = IW'((int'(rr_ptr) + k) % N_REQ);
                if (s_cmd_valid[cand]) begin
                    sel = cand;
                    found = 1'b1;
                end
            end
        end
        pay = s_cmd_payload[int'(sel)*PW +: PW];
        is_wr = pay[5];
        is_last = pay[0];
        full = count == (AW+1)'(MAX_OUTSTANDING);
        empty = count == '0;
        blk = full & ~is_wr;
        m_cmd_valid = rst_n & found & s_cmd_valid[sel] & ~blk;
        m_cmd_payload = pay;
        s_cmd_ready = '0;
        s_cmd_ready[sel] = rst_n & m_cmd_ready & ~blk;
        grant = '0;
        grant[sel] = rst_n & found;
        acc = m_cmd_valid & m_cmd_ready;
        push = acc & ~is_wr;
        pop = m_rsp_valid & m_rsp_last & ~empty;
        state_n = acc ? (is_last ? IDLE : LOCKED) : state;
        owner_n = (acc & ~is_last) ? sel : owner;
        rr_n = (acc & is_last) ? sel : rr_ptr;
        head = fifo[rd_ptr];
        s_rsp_valid = '0;
        s_rsp_valid[head] = rst_n & m_rsp_valid & ~empty;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            rr_ptr <= IW'(N_REQ - 1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rsp_orphan <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            rr_ptr <= rr_n;
            if (push) begin
                fifo[wr_ptr] <= sel;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (m_rsp_valid & empty) rsp_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hls_bus_arbiter.sv
// tb_hls_bus_arbiter: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_hls_bus_arbiter;
    localparam int N = 2, MO = 4, DW = 32, AW = 32, PW = AW + DW + 10;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] s_cmd_valid, s_cmd_ready, s_rsp_valid, grant;
    logic [N*PW-1:0] s_cmd_payload;
    logic [DW-1:0] s_rsp_data, m_rsp_data;
    logic s_rsp_last, m_cmd_valid, m_cmd_ready, m_rsp_valid, m_rsp_last, rsp_orphan;
    logic [PW-1:0] m_cmd_payload;
    int checks = 0, errors = 0;
    bit m_locked, m_orph;
    int m_owner, m_rr;
    int q[$];
    bit val [N];
    logic [PW-1:0] pay_r [N];
    bit wr_r [N];
    int left [N];
    bit last_acc;
    int last_sel;
    int cnt [N];

    always #5 clk = ~clk;

    hls_bus_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_payload(s_cmd_payload),
        .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data), .s_rsp_last(s_rsp_last),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_payload(m_cmd_payload),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_last(m_rsp_last),
        .grant(grant), .rsp_orphan(rsp_orphan)
    );

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk(logic [31:0] a, logic [31:0] d, logic w, logic l);
        return {a, d, 4'hF, w, 1'b0, 3'd2, l};
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_owner = 0;
        m_rr = N - 1;
        m_orph = 0;
        q.delete();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin
            val[i] = 0;
            pay_r[i] = '0;
            left[i] = 0;
        end
        m_cmd_ready = 1;
        m_rsp_valid = 0;
        m_rsp_last = 0;
        m_rsp_data = '0;
    endtask

    task automatic step();
        int sel;
        bit found, blk, mv, acc, popf;
        logic [PW-1:0] p;
        logic [N-1:0] oh, erv;
        for (int i = 0; i < N; i++) begin
            s_cmd_payload[i*PW +: PW] = pay_r[i];
            s_cmd_valid[i] = val[i];
        end
        #1;
        found = m_locked;
        sel = m_owner;
        if (!m_locked)
            for (int k = 1; k <= N; k++)
                if (!found && val[(m_rr + k) % N]) begin
                    found = 1;
                    sel = (m_rr + k) % N;
                end
        p = pay_r[sel];
        blk = (q.size() == MO) && !p[5];
        mv = rst_n && found && val[sel] && !blk;
        acc = mv && m_cmd_ready;
        oh = '0;
        if (rst_n && found) oh[sel] = 1'b1;
        check("grant", grant, oh);
        check("m_cmd_valid", m_cmd_valid, mv);
        if (mv) check("m_cmd_payload", m_cmd_payload, p);
        check("accept", s_cmd_ready & s_cmd_valid, acc ? oh : '0);
        erv = '0;
        if (rst_n && m_rsp_valid && q.size() > 0) erv[q[0]] = 1'b1;
        check("s_rsp_valid", s_rsp_valid, erv);
        if (m_rsp_valid) begin
            check("s_rsp_data", s_rsp_data, m_rsp_data);
            check("s_rsp_last", s_rsp_last, m_rsp_last);
        end
        check("rsp_orphan", rsp_orphan, m_orph);
        @(posedge clk);
        last_acc = acc;
        last_sel = sel;
        if (!rst_n) model_reset();
        else begin
            popf = m_rsp_valid && m_rsp_last && q.size() > 0;
            if (m_rsp_valid && q.size() == 0) m_orph = 1;
            if (acc) begin
                left[sel]--;
                if (p[0]) begin
                    m_locked = 0;
                    m_rr = sel;
                end else begin
                    m_locked = 1;
                    m_owner = sel;
                end
                if (!p[5]) q.push_back(sel);
            end
            if (popf) void'(q.pop_front());
        end
        #1;
    endtask

    task automatic gen();
        for (int i = 0; i < N; i++) begin
            if (last_acc && last_sel == i) begin
                if (left[i] > 0) pay_r[i] = mk($urandom, $urandom, wr_r[i], left[i] == 1);
                else val[i] = 0;
            end
            if (!val[i] && $urandom % 4 != 0) begin
                wr_r[i] = ($urandom % 2) == 1;
                left[i] = wr_r[i] ? 1 + int'($urandom % 4) : 1;
                val[i] = 1;
                pay_r[i] = mk($urandom, $urandom, wr_r[i], left[i] == 1);
            end
        end
        rst_n = ($urandom % 300) != 0;
        m_cmd_ready = ($urandom % 4) != 0;
        m_rsp_valid = q.size() > 0 && ($urandom % 2) == 1;
        m_rsp_last = ($urandom % 3) == 0;
        m_rsp_data = $urandom;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst_n = 1;
        // single read, one-beat response two cycles later
        val[0] = 1;
        pay_r[0] = mk(32'h40, 32'h0, 1'b0, 1'b1);
        step();
        val[0] = 0;
        step();
        step();
        m_rsp_valid = 1;
        m_rsp_last = 1;
        m_rsp_data = 32'hDEADBEEF;
        step();
        m_rsp_valid = 0;
        step();
        check("single_read_no_orphan", rsp_orphan, 1'b0);
        // fill the tracker, fifth read must wait for a freed slot
        val[1] = 1;
        pay_r[1] = mk(32'h100, 32'h0, 1'b0, 1'b1);
        repeat (4) step();
        step();
        check("full_blocks_valid", m_cmd_valid, 1'b0);
        m_rsp_valid = 1;
        m_rsp_last = 1;
        step();
        m_rsp_valid = 0;
        step();
        val[1] = 0;
        m_rsp_valid = 1;
        repeat (4) step();
        m_rsp_valid = 0;
        // routing: 8-beat burst to req0, then single beat to req1
        val[0] = 1;
        pay_r[0] = mk(32'h200, 32'h0, 1'b0, 1'b1);
        step();
        val[0] = 0;
        val[1] = 1;
        pay_r[1] = mk(32'h300, 32'h0, 1'b0, 1'b1);
        step();
        val[1] = 0;
        for (int b = 0; b < 9; b++) begin
            m_rsp_valid = 1;
            m_rsp_last = (b >= 7);
            m_rsp_data = 32'h1000 + b;
            step();
        end
        m_rsp_valid = 0;
        // contention with single-beat writes
        for (int i = 0; i < N; i++) begin
            val[i] = 1;
            pay_r[i] = mk(32'h400 + i, 32'h55, 1'b1, 1'b1);
            cnt[i] = 0;
        end
        repeat (8) begin
            step();
            if (last_acc) cnt[last_sel]++;
        end
        check("contention_req0", cnt[0], 4);
        check("contention_req1", cnt[1], 4);
        // orphan response
        idle_inputs();
        m_rsp_valid = 1;
        m_rsp_last = 1;
        step();
        m_rsp_valid = 0;
        step();
        check("orphan_set", rsp_orphan, 1'b1);
        // reset in the middle of a locked write burst
        val[1] = 1;
        pay_r[1] = mk(32'h500, 32'h1, 1'b1, 1'b0);
        repeat (2) step();
        val[0] = 1;
        pay_r[0] = mk(32'h600, 32'h2, 1'b1, 1'b1);
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        check("post_reset_grant", last_sel, 0);
        check("post_reset_orphan", rsp_orphan, 1'b0);
        // randomized traffic
        idle_inputs();
        last_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            gen();
        end
        rst_n = 1;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
